// File: rtl/alu_instr_sequencer_pkg.sv
// Shared constants for the ALU instruction sequencer: opcodes, ALU codes,
// FSM states and instruction field positions.
package alu_instr_sequencer_pkg;

  localparam logic [3:0] InsADD  = 4'h0;
  localparam logic [3:0] InsSUB  = 4'h1;
  localparam logic [3:0] InsSLTI = 4'h2;
  localparam logic [3:0] InsAND  = 4'h3;
  localparam logic [3:0] InsOR   = 4'h4;
  localparam logic [3:0] InsXOR  = 4'h5;
  localparam logic [3:0] InsANDI = 4'h6;
  localparam logic [3:0] InsORI  = 4'h7;
  localparam logic [3:0] InsXORI = 4'h8;
  localparam logic [3:0] InsADDI = 4'h9;
  localparam logic [3:0] InsSUBI = 4'hA;

  localparam logic [3:0] ALUADD = 4'd0;
  localparam logic [3:0] ALUSUB = 4'd1;
  localparam logic [3:0] ALUSLT = 4'd2;
  localparam logic [3:0] ALUAND = 4'd3;
  localparam logic [3:0] ALUOR  = 4'd4;
  localparam logic [3:0] ALUXOR = 4'd5;

  localparam int OpcLo  = 12;
  localparam int DstLo  = 8;
  localparam int RegbLo = 4;
  localparam int RegaLo = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StExec = 2'd2,
    StWb   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_instr_sequencer_decode.sv
// Combinational opcode lookup: immediate select, ALU code and illegal flag.
module alu_instr_decode
  import alu_instr_sequencer_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_imm_o,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    is_imm_o  = 1'b0;
    alu_op_o  = ALUADD;
    illegal_o = 1'b0;
    case (opcode_i)
      InsADD:  alu_op_o = ALUADD;
      InsSUB:  alu_op_o = ALUSUB;
      InsSLTI: begin is_imm_o = 1'b1; alu_op_o = ALUSLT; end
      InsAND:  alu_op_o = ALUAND;
      InsOR:   alu_op_o = ALUOR;
      InsXOR:  alu_op_o = ALUXOR;
      InsANDI: begin is_imm_o = 1'b1; alu_op_o = ALUAND; end
      InsORI:  begin is_imm_o = 1'b1; alu_op_o = ALUOR;  end
      InsXORI: begin is_imm_o = 1'b1; alu_op_o = ALUXOR; end
      InsADDI: begin is_imm_o = 1'b1; alu_op_o = ALUADD; end
      InsSUBI: begin is_imm_o = 1'b1; alu_op_o = ALUSUB; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Four-cycle control unit: accept, read operands, execute, write back.
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_e              state_q, state_d;
  logic [15:0]         instr_q;
  logic [3:0]          raddr_a_q, raddr_b_q, alu_op_q;
  logic                is_imm_q, illegal_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [CNT_W-1:0]    retired_q;
  logic                accept;
  logic                dec_is_imm, dec_illegal;
  logic [3:0]          dec_alu_op;

  alu_instr_decode u_decode (
    .opcode_i  (instr_q[OpcLo +: 4]),
    .is_imm_o  (dec_is_imm),
    .alu_op_o  (dec_alu_op),
    .illegal_o (dec_illegal)
  );

  // Ready is masked by reset so nothing is accepted while the block is held.
  assign instr_ready = RST_N && (state_q == StIdle);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = illegal_q ? StIdle : StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; every register,
  // including the datapath operands, is cleared by the async reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      alu_op_q  <= '0;
      is_imm_q  <= 1'b0;
      illegal_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q   <= instr;
        raddr_a_q <= instr[RegaLo +: 4];
        raddr_b_q <= instr[RegbLo +: 4];
      end
      if (state_q == StRead) begin
        alu_op_q  <= dec_alu_op;
        is_imm_q  <= dec_is_imm;
        illegal_q <= dec_illegal;
      end
      // Operands are captured before write-back, so DST may alias REGA/REGB.
      if (state_q == StExec && !illegal_q) begin
        alu_a_q <= rf_rdata_a;
        alu_b_q <= is_imm_q ? {{(DATA_W-4){1'b0}}, instr_q[RegbLo +: 4]} : rf_rdata_b;
      end
      if (state_q == StWb) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign rf_raddr_a = raddr_a_q;
  assign rf_raddr_b = raddr_b_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rf_we      = (state_q == StWb);
  assign rf_waddr   = instr_q[DstLo +: 4];
  assign rf_wdata   = rf_we ? alu_result : '0;
  assign busy       = (state_q != StIdle);
  assign illegal    = (state_q == StExec) && illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer with a small register-file/ALU model.
module tb_alu_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  rf_raddr_a, rf_raddr_b, alu_op, rf_waddr;
  logic [15:0] rf_rdata_a = '0, rf_rdata_b = '0;
  logic [15:0] alu_a, alu_b, alu_result, rf_wdata;
  logic        rf_we, busy, illegal;
  logic [15:0] retired;

  logic        v2 = 1'b0;
  logic        rdy2, we2, busy2, ill2;
  logic [3:0]  ra2, rb2, op2, wa2;
  logic [15:0] a2, b2, wd2;
  logic [1:0]  retired2;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int we_cnt  = 0;
  int acc_q[$];
  logic [19:0] wr_q[$];

  always #5 CLK = ~CLK;

  alu_instr_sequencer #(.DATA_W(16), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .illegal(illegal),
    .retired(retired)
  );

  alu_instr_sequencer #(.DATA_W(16), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .instr_valid(v2), .instr_ready(rdy2),
    .instr(16'h0000), .rf_raddr_a(ra2), .rf_raddr_b(rb2),
    .rf_rdata_a(16'h0000), .rf_rdata_b(16'h0000), .alu_op(op2),
    .alu_a(a2), .alu_b(b2), .alu_result(16'h0000), .rf_we(we2),
    .rf_waddr(wa2), .rf_wdata(wd2), .busy(busy2), .illegal(ill2),
    .retired(retired2)
  );

  // Register file holds R2=7, R3=5, all others 0; read data lags address by one cycle.
  function automatic logic [15:0] rf_val(input logic [3:0] a);
    return (a == 4'd2) ? 16'd7 : (a == 4'd3) ? 16'd5 : 16'd0;
  endfunction

  always @(posedge CLK) begin
    rf_rdata_a <= rf_val(rf_raddr_a);
    rf_rdata_b <= rf_val(rf_raddr_b);
  end

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = {15'd0, ($signed(alu_a) < $signed(alu_b))};
      4'd3: alu_result = alu_a & alu_b;
      4'd4: alu_result = alu_a | alu_b;
      4'd5: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  always @(negedge CLK) begin
    cyc++;
    if (instr_valid && instr_ready) acc_q.push_back(cyc);
    if (rf_we) begin
      we_cnt++;
      wr_q.push_back({rf_waddr, rf_wdata});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%0d exp=0", instr_ready); end
    n_total++; if ({busy, rf_we, illegal} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b exp=000", {busy, rf_we, illegal}); end
    n_total++; if ({alu_a, alu_b, retired} !== 48'd0) begin n_bad++; $display("FAIL rst_data got=%h exp=0", {alu_a, alu_b, retired}); end
    tick();
    RST_N = 1'b1;
    #1;
    n_total++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%0d exp=1", instr_ready); end
  endtask

  // One legal instruction with operands R2/R3 (or IMM) and destination R4.
  task automatic test_legal_op(input string nm, input logic [15:0] ins, input logic [3:0] e_rb,
                               input logic [3:0] e_op, input logic [15:0] e_b,
                               input logic [15:0] e_wd, input logic [15:0] e_ret);
    instr = ins; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_total++; if ({rf_raddr_a, rf_raddr_b} !== {4'd2, e_rb}) begin n_bad++; $display("FAIL %s_raddr got=%h exp=%h", nm, {rf_raddr_a, rf_raddr_b}, {4'd2, e_rb}); end
    n_total++; if ({busy, instr_ready} !== 2'b10) begin n_bad++; $display("FAIL %s_busy got=%b exp=10", nm, {busy, instr_ready}); end
    tick();
    n_total++; if (alu_op !== e_op) begin n_bad++; $display("FAIL %s_aluop got=%0d exp=%0d", nm, alu_op, e_op); end
    n_total++; if ({rf_we, illegal} !== 2'b00) begin n_bad++; $display("FAIL %s_exec_flags got=%b exp=00", nm, {rf_we, illegal}); end
    tick();
    n_total++; if ({alu_a, alu_b} !== {16'd7, e_b}) begin n_bad++; $display("FAIL %s_operands got=%0d,%0d exp=7,%0d", nm, alu_a, alu_b, e_b); end
    n_total++; if ({rf_we, rf_waddr} !== {1'b1, 4'd4}) begin n_bad++; $display("FAIL %s_wb got=%b exp=10100", nm, {rf_we, rf_waddr}); end
    n_total++; if (rf_wdata !== e_wd) begin n_bad++; $display("FAIL %s_wdata got=%0d exp=%0d", nm, rf_wdata, e_wd); end
    tick();
    n_total++; if ({rf_we, instr_ready} !== 2'b01) begin n_bad++; $display("FAIL %s_idle got=%b exp=01", nm, {rf_we, instr_ready}); end
    n_total++; if (retired !== e_ret) begin n_bad++; $display("FAIL %s_retired got=%0d exp=%0d", nm, retired, e_ret); end
  endtask

  task automatic test_illegal();
    int we0;
    we0 = we_cnt;
    instr = 16'hB123; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    n_total++; if ({illegal, rf_we, busy} !== 3'b101) begin n_bad++; $display("FAIL ill_exec got=%b exp=101", {illegal, rf_we, busy}); end
    tick();
    n_total++; if ({instr_ready, illegal, busy} !== 3'b100) begin n_bad++; $display("FAIL ill_after got=%b exp=100", {instr_ready, illegal, busy}); end
    n_total++; if (retired !== 16'd4) begin n_bad++; $display("FAIL ill_retired got=%0d exp=4", retired); end
    n_total++; if (we_cnt !== we0) begin n_bad++; $display("FAIL ill_we got=%0d exp=%0d", we_cnt - we0, 0); end
  endtask

  task automatic test_back_to_back();
    int a0, w0, d0;
    a0 = acc_q.size(); w0 = we_cnt; d0 = wr_q.size();
    instr = 16'h0432; instr_valid = 1'b1;
    tick();
    instr = 16'h5532;
    repeat (4) tick();
    instr_valid = 1'b0;
    repeat (3) tick();
    n_total++; if (acc_q.size() - a0 != 2) begin n_bad++; $display("FAIL b2b_accepts got=%0d exp=2", acc_q.size() - a0); end
    else begin
      n_total++; if (acc_q[a0+1] - acc_q[a0] != 4) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=4", acc_q[a0+1] - acc_q[a0]); end
    end
    n_total++; if (we_cnt - w0 != 2) begin n_bad++; $display("FAIL b2b_we_pulses got=%0d exp=2", we_cnt - w0); end
    else begin
      n_total++; if ({wr_q[d0], wr_q[d0+1]} !== {4'd4, 16'd12, 4'd5, 16'd2}) begin n_bad++; $display("FAIL b2b_writes got=%h exp=%h", {wr_q[d0], wr_q[d0+1]}, {4'd4, 16'd12, 4'd5, 16'd2}); end
    end
    n_total++; if (retired !== 16'd6) begin n_bad++; $display("FAIL b2b_retired got=%0d exp=6", retired); end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = we_cnt;
    instr = 16'h0432; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    RST_N = 1'b0;
    #1;
    n_total++; if ({rf_we, busy, illegal, instr_ready} !== 4'b0000) begin n_bad++; $display("FAIL rmid_flags got=%b exp=0000", {rf_we, busy, illegal, instr_ready}); end
    n_total++; if ({alu_a, alu_b, alu_op, rf_raddr_a, rf_raddr_b, retired} !== 60'd0) begin n_bad++; $display("FAIL rmid_data got=%h exp=0", {alu_a, alu_b, alu_op, rf_raddr_a, rf_raddr_b, retired}); end
    tick();
    RST_N = 1'b1;
    repeat (3) tick();
    n_total++; if (we_cnt !== w0) begin n_bad++; $display("FAIL rmid_no_we got=%0d exp=0", we_cnt - w0); end
    test_legal_op("rmid_add", 16'h0432, 4'd3, 4'd0, 16'd5, 16'd12, 16'd1);
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    v2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      repeat (3) tick();
      if (k == 4) v2 = 1'b0;
      n_total++; if (retired2 !== exp_seq[k]) begin n_bad++; $display("FAIL wrap_%0d got=%0d exp=%0d", k, retired2, exp_seq[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_legal_op("add",  16'h0432, 4'd3, 4'd0, 16'd5,  16'd12, 16'd1);
    test_legal_op("addi", 16'h94F2, 4'hF, 4'd0, 16'd15, 16'd22, 16'd2);
    test_legal_op("sub",  16'h1432, 4'd3, 4'd1, 16'd5,  16'd2,  16'd3);
    test_legal_op("slti", 16'h2482, 4'd8, 4'd2, 16'd8,  16'd1,  16'd4);
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_counter_wrap();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Multi-cycle control unit that accepts one 16-bit instruction (opcode[15:12], DST[11:8], IMM|REGB[7:4], REGA[3:0]) and sequences operand read, ALU execution and register write-back.
- Drives register-file read and write ports, ALU operation code, operand registers and immediate select.
- Sits between the instruction source and the register file / ALU pair, replacing ad-hoc per-opcode control.

Parameters:
DATA_W, 16, register/ALU data width; 4-bit IMM is zero-extended to DATA_W
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept; high only in IDLE
instr  in  16  instruction word, sampled when instr_valid && instr_ready
rf_raddr_a  out  4  register-file read address A (REGA)
rf_raddr_b  out  4  register-file read address B (REGB)
rf_rdata_a  in  DATA_W  read data A, valid one cycle after address
rf_rdata_b  in  DATA_W  read data B, valid one cycle after address
alu_op  out  4  ALU code: ADD=0, SUB=1, SLT=2, AND=3, OR=4, XOR=5
alu_a  out  DATA_W  registered ALU operand A
alu_b  out  DATA_W  registered ALU operand B (register or zero-extended IMM)
alu_result  in  DATA_W  combinational ALU result
rf_we  out  1  register write enable, one-cycle pulse
rf_waddr  out  4  write address (DST)
rf_wdata  out  DATA_W  write data
busy  out  1  high in any state except IDLE
illegal  out  1  one-cycle pulse on undefined opcode
retired  out  CNT_W  count of completed write-backs, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, RST_N=0): state=IDLE; all outputs and internal registers 0; instr_ready=1 once RST_N deasserts.
- Reset mid-operation: the pending instruction is discarded. No rf_we is issued.
- Opcode map, immediate select isImm, ALU code:
  - 0000 ADD: isImm=0, ADD
  - 0001 SUB: isImm=0, SUB
  - 0010 SLTI: isImm=1, SLT
  - 0011 AND: isImm=0, AND
  - 0100 OR: isImm=0, OR
  - 0101 XOR: isImm=0, XOR
  - 0110 ANDI: isImm=1, AND
  - 0111 ORI: isImm=1, OR
  - 1000 XORI: isImm=1, XOR
  - 1001 ADDI: isImm=1, ADD
  - 1010 SUBI: isImm=1, SUB
  - 1011-1111: illegal
- FSM IDLE -> READ -> EXEC -> WB -> IDLE. Handshake at cycle 0; instruction latched into internal register.
  - READ (cycle 1): rf_raddr_a=REGA, rf_raddr_b=REGB[7:4]; alu_op and isImm decoded and registered.
  - EXEC (cycle 2): alu_a <= rf_rdata_a; alu_b <= isImm ? zero-extended instr[7:4] : rf_rdata_b.
    - Illegal opcode: illegal=1 for this cycle, next state IDLE, no WB.
  - WB (cycle 3): rf_we=1, rf_waddr=DST, rf_wdata=alu_result; retired increments by 1, wrapping at 2^CNT_W-1 -> 0.
  - Cycle 4: back in IDLE, instr_ready=1.
- Throughput: one instruction per 4 cycles.
- instr_valid while busy: ignored. The source must hold valid; the instruction is accepted on the next IDLE cycle.
- instr changing while not accepted: no effect.
- All 16 registers are writable, including DST=0.
- DST equal to REGA/REGB: legal. Write occurs after the operands are captured.
- rf_raddr_*, alu_a, alu_b and alu_op hold their last value outside active states.
- rf_we and illegal are 0 except in their single-cycle windows.

Decomposition:
- Shared package holds opcode constants (InsADD..InsSUBI), ALU code constants (ALUADD..ALUXOR), the FSM state enum and the instruction field bit positions.
- Natural sub-module: alu_instr_decode, a purely combinational opcode -> {isImm, alu_op, illegal} lookup reused by other control blocks. The FSM and counters stay in the top.

Test Plan:
- Bench register-file model holds R2=7 and R3=5.
- ADD 0x0432 -> cycle 1: raddr_a=2, raddr_b=3; cycle 2: alu_a=7, alu_b=5, alu_op=0; cycle 3: rf_we=1, waddr=4, wdata=12; retired=1.
- ADDI 0x94F2 -> alu_b=15 (zero-extended IMM), wdata=22, waddr=4.
- SUB 0x1432 -> wdata=2. SLTI 0x2482 (IMM=8) -> alu_op=2, alu_b=8, wdata=1.
- Illegal 0xB123 -> illegal pulses in cycle 2; no rf_we; retired unchanged; instr_ready=1 at cycle 3.
- instr_valid held high with ADD then XOR back-to-back -> second accepted exactly 4 cycles after the first; exactly two rf_we pulses.
- RST_N low during EXEC -> all outputs 0 immediately, no rf_we; after release a fresh ADD completes normally.
- CNT_W=2, retire 5 instructions -> retired sequence 1, 2, 3, 0, 1.
